tone_synth: RTL and testbench

//  Consumer side of the note-sequencer interface: takes two 11-bit note frequencies (Hz) and

---
 rtl/tone_synth_pkg.sv | 9 +
 rtl/tone_synth_divider.sv | 57 +++++
 rtl/tone_synth.sv | 142 ++++++++++++++
 tb/tb_tone_synth.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tone_synth_pkg.sv
// Shared widths and divider FSM encoding for the two-voice square-wave synth.
package tone_synth_pkg;
  localparam int FREQ_W = 11;
  localparam int HALF_W = 26;
  localparam int MIX_W  = 17;
  localparam int DIVR_W = 12;

  typedef enum logic [1:0] {IDLE, DIV1, DIV2} div_state_t;
endpackage

// File: rtl/tone_synth_divider.sv
// Restoring divider: 26-bit dividend / 12-bit divisor, one quotient bit per clk.
// done pulses 27 clk after the start cycle; quotient holds until the next start.
module seq_divider
  import tone_synth_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HALF_W-1:0] dividend,
  input  logic [DIVR_W-1:0] divisor,
  output logic              done,
  output logic [HALF_W-1:0] quotient
);
  logic [DIVR_W-1:0] rem;
  logic [DIVR_W-1:0] dvs;
  logic [4:0]        bits;
  logic              run;
  logic [DIVR_W:0]   trial;
  logic [DIVR_W:0]   diff;

  // quotient doubles as the dividend shift register
  assign trial = {rem, quotient[HALF_W-1]};
  assign diff  = trial - {1'b0, dvs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      dvs      <= '0;
      bits     <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= dividend;
        rem      <= '0;
        dvs      <= divisor;
        bits     <= 5'(HALF_W);
        run      <= 1'b1;
      end else if (run) begin
        if (trial >= {1'b0, dvs}) begin
          rem      <= diff[DIVR_W-1:0];
          quotient <= {quotient[HALF_W-2:0], 1'b1};
        end else begin
          rem      <= trial[DIVR_W-1:0];
          quotient <= {quotient[HALF_W-2:0], 1'b0};
        end
        bits <= bits - 5'd1;
        if (bits == 5'd1) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/tone_synth.sv
// Two square-wave voices from Hz inputs, half-periods from one shared divider,
// plus a registered signed mix sample with a fixed-rate strobe.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SAMPLE_DIV = 1042,
  parameter int AMP        = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [FREQ_W-1:0]       freq1,
  input  logic [FREQ_W-1:0]       freq2,
  output logic                    tone1,
  output logic                    tone2,
  output logic signed [MIX_W-1:0] mix,
  output logic                    sample_valid,
  output logic                    busy
);
  localparam int SW = $clog2(SAMPLE_DIV);

  div_state_t state, state_nxt;
  logic [1:0][FREQ_W-1:0] freq_in, req_freq;
  logic [1:0][HALF_W-1:0] next_half, cur_half, cnt;
  logic [1:0]             pend, clr_pend, wr, tone;
  logic                   start, done;
  logic [DIVR_W-1:0]      divisor;
  logic [HALF_W-1:0]      quotient;
  logic [SW-1:0]          scnt;

  assign freq_in = {freq2, freq1};
  assign wr[0]   = done && (state == DIV1);
  assign wr[1]   = done && (state == DIV2);
  assign busy    = (state != IDLE) || (|pend);
  assign tone1   = tone[0];
  assign tone2   = tone[1];

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (HALF_W'(CLK_HZ)),
    .divisor  (divisor),
    .done     (done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    clr_pend  = 2'b00;
    divisor   = {req_freq[0], 1'b0};
    case (state)
      IDLE: begin
        if (pend[0]) begin
          state_nxt   = DIV1;
          start       = 1'b1;
          clr_pend[0] = 1'b1;
        end else if (pend[1]) begin
          state_nxt   = DIV2;
          start       = 1'b1;
          clr_pend[1] = 1'b1;
          divisor     = {req_freq[1], 1'b0};
        end
      end
      DIV1, DIV2: if (done) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Later assignments win: a change or silence overrides a clear or a result write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_freq  <= '0;
      pend      <= '0;
      next_half <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (clr_pend[v]) pend[v] <= 1'b0;
        if (wr[v] && req_freq[v] != '0) next_half[v] <= quotient;
        if (freq_in[v] != req_freq[v]) begin
          req_freq[v] <= freq_in[v];
          if (freq_in[v] == '0) begin
            pend[v]      <= 1'b0;
            next_half[v] <= '0;
          end else begin
            pend[v] <= 1'b1;
          end
        end
      end
    end
  end

  // Period changes only land at a half-period boundary, so no runt pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_half <= '0;
      cnt      <= '0;
      tone     <= '0;
    end else if (en) begin
      for (int v = 0; v < 2; v++) begin
        if (cur_half[v] == '0) begin
          tone[v] <= 1'b0;
          cnt[v]  <= '0;
          if (next_half[v] != '0) cur_half[v] <= next_half[v];
        end else if (cnt[v] == cur_half[v] - HALF_W'(1)) begin
          cnt[v]      <= '0;
          cur_half[v] <= next_half[v];
          tone[v]     <= (next_half[v] != '0) ? ~tone[v] : 1'b0;
        end else begin
          cnt[v] <= cnt[v] + HALF_W'(1);
        end
      end
    end
  end

  function automatic logic signed [MIX_W-1:0] contrib(input logic t, input logic [HALF_W-1:0] h);
    if (h == '0) return '0;
    return t ? MIX_W'(AMP) : -MIX_W'(AMP);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt         <= '0;
      sample_valid <= 1'b0;
      mix          <= '0;
    end else if (scnt == SW'(SAMPLE_DIV - 1)) begin
      scnt         <= '0;
      sample_valid <= 1'b1;
      mix          <= contrib(tone[0], cur_half[0]) + contrib(tone[1], cur_half[1]);
    end else begin
      scnt         <= scnt + SW'(1);
      sample_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tone_synth.sv
// Randomized scenario bench for tone_synth; expectations come from Hz arithmetic.
module tb_tone_synth;
  localparam int CLK_HZ     = 1_000_000;
  localparam int SAMPLE_DIV = 1042;
  localparam int AMP        = 8192;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b1;
  logic [10:0]        freq1 = '0;
  logic [10:0]        freq2 = '0;
  logic               tone1, tone2, sample_valid, busy;
  logic signed [16:0] mix;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  tone_synth #(.CLK_HZ(CLK_HZ), .SAMPLE_DIV(SAMPLE_DIV), .AMP(AMP)) dut (
    .clk(clk), .reset(reset), .en(en), .freq1(freq1), .freq2(freq2),
    .tone1(tone1), .tone2(tone2), .mix(mix), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int half_of(input int f);
    return (f == 0) ? 0 : CLK_HZ / (2 * f);
  endfunction

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; freq1 = '0; freq2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_level(input int v, input logic lvl, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (((v == 1) ? tone1 : tone2) === lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    freq1 = 11'd440;
    repeat (2) @(negedge clk);
    checks++; if (tone1 !== 1'b0) begin errors++; $display("FAIL reset_tone1 got %b want 0", tone1); end
    checks++; if (tone2 !== 1'b0) begin errors++; $display("FAIL reset_tone2 got %b want 0", tone2); end
    checks++; if (mix !== 17'sd0) begin errors++; $display("FAIL reset_mix got %0d want 0", mix); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b want 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_voice();
    int n, h, r0, last, ntog;
    logic prev, et;
    logic signed [16:0] em;
    h = half_of(440);
    do_reset();
    freq1 = 11'd440;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    checks++; if (n < 1 || n > 28 || busy !== 1'b0) begin errors++; $display("FAIL busy_time got %0d cycles want 1..28", n); end
    wait_level(1, 1'b1, h + 100, r0);
    checks++; if (r0 < 0) begin errors++; $display("FAIL first_rise got timeout want rise"); end
    last = r0; ntog = 0; prev = 1'b1;
    for (int i = 0; i < 3 * h; i++) begin
      @(negedge clk);
      if (tone1 !== prev) begin
        checks++; if (cyc - last != h) begin errors++; $display("FAIL half_440 got %0d want %0d", cyc - last, h); end
        last = cyc; ntog++; prev = tone1;
      end
      if (sample_valid) begin
        et = (((cyc - 1 - r0) / h) % 2 == 0);
        em = et ? 17'(AMP) : -17'(AMP);
        checks++; if (mix !== em) begin errors++; $display("FAIL mix_single got %0d want %0d", mix, em); end
        checks++; if (tone2 !== 1'b0) begin errors++; $display("FAIL tone2_silent got %b want 0", tone2); end
      end
    end
    checks++; if (ntog < 2) begin errors++; $display("FAIL toggles_440 got %0d want >=2", ntog); end
  endtask

  task automatic test_pair(input int f1, input int f2);
    int h1, h2, r1, fl1, r2, fl2, bound, d;
    logic p1, p2;
    h1 = half_of(f1); h2 = half_of(f2);
    do_reset();
    freq1 = 11'(f1); freq2 = 11'(f2);
    r1 = -1; fl1 = -1; r2 = -1; fl2 = -1; p1 = 1'b0; p2 = 1'b0;
    bound = 2 * ((h1 > h2) ? h1 : h2) + 300;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tone1 && !p1 && r1 < 0) r1 = cyc;
      if (!tone1 && p1 && fl1 < 0) fl1 = cyc;
      if (tone2 && !p2 && r2 < 0) r2 = cyc;
      if (!tone2 && p2 && fl2 < 0) fl2 = cyc;
      p1 = tone1; p2 = tone2;
      if (fl1 >= 0 && fl2 >= 0) break;
    end
    checks++; if (r1 < 0 || fl1 - r1 != h1) begin errors++; $display("FAIL pair_half1 f=%0d got %0d want %0d", f1, fl1 - r1, h1); end
    checks++; if (r2 < 0 || fl2 - r2 != h2) begin errors++; $display("FAIL pair_half2 f=%0d got %0d want %0d", f2, fl2 - r2, h2); end
    d = (r2 - h2) - (r1 - h1);
    checks++; if (d <= 0 || d > 56) begin errors++; $display("FAIL pair_order got v2-v1 start %0d want 1..56", d); end
  endtask

  task automatic test_retune();
    int ha, hb, r0, t1, t2, t3;
    ha = half_of(440); hb = half_of(294);
    do_reset();
    freq1 = 11'd440;
    wait_level(1, 1'b1, ha + 100, r0);
    repeat ($urandom_range(ha - 100, 100)) @(negedge clk);
    freq1 = 11'd294;
    wait_level(1, 1'b0, ha + 10, t1);
    checks++; if (r0 < 0 || t1 - r0 != ha) begin errors++; $display("FAIL retune_old_half got %0d want %0d", t1 - r0, ha); end
    wait_level(1, 1'b1, hb + 10, t2);
    checks++; if (t1 < 0 || t2 - t1 != hb) begin errors++; $display("FAIL retune_new_half1 got %0d want %0d", t2 - t1, hb); end
    wait_level(1, 1'b0, hb + 10, t3);
    checks++; if (t2 < 0 || t3 - t2 != hb) begin errors++; $display("FAIL retune_new_half2 got %0d want %0d", t3 - t2, hb); end
  endtask

  task automatic test_freq_zero();
    int h, r0, f0, term, highs;
    logic signed [16:0] em;
    h = half_of(440);
    do_reset();
    freq1 = 11'd440;
    wait_level(1, 1'b1, h + 100, r0);
    wait_level(1, 1'b0, h + 10, f0);
    checks++; if (r0 < 0 || f0 - r0 != h) begin errors++; $display("FAIL zero_pre_half got %0d want %0d", f0 - r0, h); end
    repeat ($urandom_range(h - 100, 50)) @(negedge clk);
    freq1 = 11'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_no_divide busy got %b want 0", busy); end
    term = f0 + h; highs = 0;
    for (int i = 0; i < 3 * h; i++) begin
      @(negedge clk);
      if (tone1) highs++;
      if (sample_valid) begin
        em = (cyc <= term) ? -17'(AMP) : 17'sd0;
        checks++; if (mix !== em) begin errors++; $display("FAIL zero_mix got %0d want %0d", mix, em); end
      end
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL zero_tone_held got %0d high cycles want 0", highs); end
  endtask

  task automatic test_enable_hold();
    int h, r0, fl, last, nstr;
    h = half_of(440);
    do_reset();
    freq1 = 11'd440;
    wait_level(1, 1'b1, h + 100, r0);
    repeat ($urandom_range(100, 10)) @(negedge clk);
    en = 1'b0;
    fl = -1; last = -1; nstr = 0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (i == 999) en = 1'b1;
      if (!tone1 && fl < 0) fl = cyc;
      if (sample_valid) begin
        if (last >= 0) begin
          checks++; if (cyc - last != SAMPLE_DIV) begin errors++; $display("FAIL en_strobe_period got %0d want %0d", cyc - last, SAMPLE_DIV); end
        end
        last = cyc; nstr++;
      end
    end
    checks++; if (r0 < 0 || fl - r0 != h + 1000) begin errors++; $display("FAIL en_hold_half got %0d want %0d", fl - r0, h + 1000); end
    checks++; if (nstr < 2) begin errors++; $display("FAIL en_strobes got %0d want >=2", nstr); end
  endtask

  task automatic test_reset_mid_divide();
    int h, r0, x, s1, s2, r1, fl1;
    logic p1;
    h = half_of(2047);
    do_reset();
    freq1 = 11'd440;
    wait_level(1, 1'b1, half_of(440) + 100, r0);
    freq1 = 11'd2047;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_divide_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tone1 !== 1'b0 || tone2 !== 1'b0) begin errors++; $display("FAIL arst_tones got %b%b want 00", tone1, tone2); end
    checks++; if (mix !== 17'sd0 || sample_valid !== 1'b0) begin errors++; $display("FAIL arst_mix got %0d/%b want 0/0", mix, sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    x = cyc; s1 = -1; s2 = -1; r1 = -1; fl1 = -1; p1 = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        if (s1 < 0) s1 = cyc;
        else if (s2 < 0) s2 = cyc;
      end
      if (tone1 && !p1 && r1 < 0) r1 = cyc;
      if (!tone1 && p1 && fl1 < 0) fl1 = cyc;
      p1 = tone1;
      if (s2 >= 0 && fl1 >= 0) break;
    end
    checks++; if (s1 - x != SAMPLE_DIV) begin errors++; $display("FAIL first_strobe got %0d want %0d", s1 - x, SAMPLE_DIV); end
    checks++; if (s1 < 0 || s2 - s1 != SAMPLE_DIV) begin errors++; $display("FAIL strobe_period got %0d want %0d", s2 - s1, SAMPLE_DIV); end
    checks++; if (r1 < 0 || fl1 - r1 != h) begin errors++; $display("FAIL half_2047 got %0d want %0d", fl1 - r1, h); end
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_pair(349, 330);
    for (int k = 0; k < 3; k++) test_pair($urandom_range(2047, 300), $urandom_range(2047, 300));
    test_retune();
    test_freq_zero();
    test_enable_hold();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
